// File: rtl/div_pkg.sv
// div_pkg: shared types for the radix-4 SRT divider request front-end.
// Width default, one-hot FSM encoding, special-case classes, bypass results.
package div_pkg;

  localparam int DIV_XLEN = 64;

  localparam logic [3:0] ST_IDLE_OH  = 4'b0001;
  localparam logic [3:0] ST_ISSUE_OH = 4'b0010;
  localparam logic [3:0] ST_WAIT_OH  = 4'b0100;
  localparam logic [3:0] ST_RESP_OH  = 4'b1000;

  typedef enum logic [3:0] {
    ST_IDLE  = ST_IDLE_OH,
    ST_ISSUE = ST_ISSUE_OH,
    ST_WAIT  = ST_WAIT_OH,
    ST_RESP  = ST_RESP_OH
  } div_state_e;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_DZ,
    CLS_ZERO,
    CLS_ONE,
    CLS_NEG1
  } div_cls_e;

  typedef struct packed {
    logic [DIV_XLEN-1:0] quo;
    logic [DIV_XLEN-1:0] rem;
    logic                dz;
  } div_res_t;

  // Locally resolved result for a classified operand pair.
  function automatic div_res_t div_bypass(
    input div_cls_e            cls,
    input logic [DIV_XLEN-1:0] op1
  );
    div_res_t r;
    r = '0;
    unique case (cls)
      CLS_DZ: begin
        r.quo = '1;
        r.rem = op1;
        r.dz  = 1'b1;
      end
      CLS_ONE:  r.quo = op1;
      CLS_NEG1: r.quo = -op1;
      CLS_ZERO: r = '0;
      CLS_NONE: r = '0;
      default:  r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/div_req_fifo.sv
// div_req_fifo: registered in-order request queue for the divider front-end.
// Pointers carry an extra wrap bit to tell full from empty.
module div_req_fifo
  import div_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 2 * DIV_XLEN + 4
)(
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;

  assign o_head  = r_mem[r_rptr[AW-1:0]];
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  // Entry storage, written at the write pointer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_push) begin
      r_mem[r_wptr[AW-1:0]] <= i_data;
    end
  end

  // Read/write pointers wrap modulo DEPTH plus the wrap bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: queues divide requests, bypasses special operands, issues
// the rest to the SRT core. DIV_BYPASS_EN enables op1==0 / op2==+-1 bypass.
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int XLEN  = DIV_XLEN,
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
)(
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_vld_i,
  output logic             req_rdy_o,
  input  logic [XLEN-1:0]  req_op1_i,
  input  logic [XLEN-1:0]  req_op2_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             rsp_vld_o,
  input  logic             rsp_rdy_i,
  output logic [XLEN-1:0]  rsp_quo_o,
  output logic [XLEN-1:0]  rsp_rem_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             rsp_dz_o,
  output logic             core_vld_o,
  output logic [XLEN-1:0]  core_op1_o,
  output logic [XLEN-1:0]  core_op2_o,
  input  logic             core_ready_i,
  input  logic [XLEN-1:0]  core_quo_i,
  input  logic [XLEN-1:0]  core_rem_i
);

  localparam int EW = 2 * XLEN + TAG_W;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [EW-1:0]    w_head;
  logic [XLEN-1:0]  w_hop1;
  logic [XLEN-1:0]  w_hop2;
  logic [TAG_W-1:0] w_htag;
  logic             w_act;
  logic             w_load;
  logic             w_cap;
  div_state_e       r_state;
  div_state_e       w_nxt;
  div_cls_e         w_cls;
  div_res_t         w_byp;
  logic             r_rdy;
  logic             r_seen_busy;
  logic [XLEN-1:0]  r_quo;
  logic [XLEN-1:0]  r_rem;
  logic             r_dz;

  assign req_rdy_o = r_rdy & ~w_full;
  assign w_push    = req_vld_i & req_rdy_o;
  assign w_pop     = rsp_vld_o & rsp_rdy_i;

  div_req_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_data  ({req_tag_i, req_op1_i, req_op2_i}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_hop2 = w_head[XLEN-1:0];
  assign w_hop1 = w_head[2*XLEN-1:XLEN];
  assign w_htag = w_head[EW-1:2*XLEN];
  assign w_act  = (r_state != ST_IDLE);

  assign core_vld_o = (r_state == ST_ISSUE);
  assign core_op1_o = w_act ? w_hop1 : '0;
  assign core_op2_o = w_act ? w_hop2 : '0;
  assign rsp_vld_o  = (r_state == ST_RESP);
  assign rsp_tag_o  = rsp_vld_o ? w_htag : '0;
  assign rsp_quo_o  = r_quo;
  assign rsp_rem_o  = r_rem;
  assign rsp_dz_o   = r_dz;

  // Classify the head entry; a zero divisor is always resolved here.
  always_comb begin
    w_cls = CLS_NONE;
    if (w_hop2 == '0) w_cls = CLS_DZ;
`ifdef DIV_BYPASS_EN
    else if (w_hop1 == '0) w_cls = CLS_ZERO;
    else if (w_hop2 == XLEN'(1)) w_cls = CLS_ONE;
    else if (&w_hop2) w_cls = CLS_NEG1;
`endif
  end

  assign w_byp = div_bypass(w_cls, w_hop1);

  // Next-state logic with bypass-load and core-capture strobes.
  always_comb begin
    w_nxt  = r_state;
    w_load = 1'b0;
    w_cap  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          if (w_cls != CLS_NONE) begin
            w_load = 1'b1;
            w_nxt  = ST_RESP;
          end else begin
            w_nxt = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: if (core_ready_i) w_nxt = ST_WAIT;
      ST_WAIT: begin
        if (r_seen_busy && core_ready_i) begin
          w_cap = 1'b1;
          w_nxt = ST_RESP;
        end
      end
      ST_RESP: if (rsp_rdy_i) w_nxt = ST_IDLE;
      default: w_nxt = ST_IDLE;
    endcase
  end

  // State register and tracking of the core going busy after issue.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_seen_busy <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (r_state == ST_ISSUE) r_seen_busy <= 1'b0;
      else if (r_state == ST_WAIT && !core_ready_i)
        r_seen_busy <= 1'b1;
    end
  end

  // Result register, loaded from the bypass or from the core.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_quo <= '0;
      r_rem <= '0;
      r_dz  <= 1'b0;
    end else if (w_load) begin
      r_quo <= w_byp.quo;
      r_rem <= w_byp.rem;
      r_dz  <= w_byp.dz;
    end else if (w_cap) begin
      r_quo <= core_quo_i;
      r_rem <= core_rem_i;
      r_dz  <= 1'b0;
    end
  end

  // Ready stays low through reset and rises on the first clock after.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_rdy <= 1'b0;
    else       r_rdy <= 1'b1;
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: vector table, directed corner cases and randomized
// traffic against a queue-based arithmetic reference model.
module tb_div_issue_ctrl;

  localparam int XLEN  = 64;
  localparam int DEPTH = 2;
  localparam int TAG_W = 4;
`ifdef DIV_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = '1;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             req_vld_i = 1'b0;
  logic             req_rdy_o;
  logic [XLEN-1:0]  req_op1_i = '0;
  logic [XLEN-1:0]  req_op2_i = '0;
  logic [TAG_W-1:0] req_tag_i = '0;
  logic             rsp_vld_o;
  logic             rsp_rdy_i = 1'b0;
  logic [XLEN-1:0]  rsp_quo_o;
  logic [XLEN-1:0]  rsp_rem_o;
  logic [TAG_W-1:0] rsp_tag_o;
  logic             rsp_dz_o;
  logic             core_vld_o;
  logic [XLEN-1:0]  core_op1_o;
  logic [XLEN-1:0]  core_op2_o;
  logic             core_ready_i = 1'b1;
  logic [XLEN-1:0]  core_quo_i = '0;
  logic [XLEN-1:0]  core_rem_i = '0;

  always #5 clk = ~clk;

  div_issue_ctrl #(
    .XLEN (XLEN), .DEPTH (DEPTH), .TAG_W (TAG_W)
  ) dut (
    .clk (clk), .rstn (rstn),
    .req_vld_i (req_vld_i), .req_rdy_o (req_rdy_o),
    .req_op1_i (req_op1_i), .req_op2_i (req_op2_i),
    .req_tag_i (req_tag_i),
    .rsp_vld_o (rsp_vld_o), .rsp_rdy_i (rsp_rdy_i),
    .rsp_quo_o (rsp_quo_o), .rsp_rem_o (rsp_rem_o),
    .rsp_tag_o (rsp_tag_o), .rsp_dz_o (rsp_dz_o),
    .core_vld_o (core_vld_o),
    .core_op1_o (core_op1_o), .core_op2_o (core_op2_o),
    .core_ready_i (core_ready_i),
    .core_quo_i (core_quo_i), .core_rem_i (core_rem_i)
  );

  typedef struct packed {
    logic [63:0] quo;
    logic [63:0] rem;
    logic        dz;
    logic [3:0]  tag;
  } rsp_t;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  t;
    logic [63:0] q;
    logic [63:0] r;
    logic        dz;
    int          hs;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  int hs_cnt = 0;
  int core_lat = 0;
  bit core_block = 1'b0;
  bit c_hs;
  int busy = 0;
  vec_t vt[11];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Signed truncating division, MIN/-1 wraps, zero divisor flagged.
  function automatic rsp_t ref_div(input logic [63:0] a,
                                   input logic [63:0] b,
                                   input logic [3:0]  t);
    rsp_t   r;
    longint sa;
    longint sb;
    sa = longint'(a);
    sb = longint'(b);
    r.tag = t;
    r.dz  = (b == 64'd0);
    if (b == 64'd0) begin
      r.quo = ONES;
      r.rem = a;
    end else if (sb == -64'sd1) begin
      r.quo = -a;
      r.rem = 64'd0;
    end else begin
      r.quo = 64'(sa / sb);
      r.rem = 64'(sa % sb);
    end
    return r;
  endfunction

  function automatic bit goes_core(input logic [63:0] a,
                                   input logic [63:0] b);
    if (b == 64'd0) return 1'b0;
    if (BYP && (a == 64'd0 || b == 64'd1 || b == ONES)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [63:0] gen_op1();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return MINV;
      2: return {$urandom, $urandom};
      default: return 64'(longint'($urandom_range(0, 2000)) - 1000);
    endcase
  endfunction

  function automatic logic [63:0] gen_op2();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return 64'd1;
      2: return ONES;
      3: return {$urandom, $urandom};
      default: return 64'(longint'($urandom_range(0, 100)) - 50);
    endcase
  endfunction

  // Core model: busy for a few cycles after each accepted issue.
  initial begin
    forever begin
      @(negedge clk);
      c_hs = rstn && core_vld_o && core_ready_i;
      @(posedge clk);
      #1;
      if (!rstn) begin
        busy = 0;
        core_ready_i = !core_block;
      end else if (c_hs) begin
        rsp_t cr;
        hs_cnt++;
        cr = ref_div(core_op1_o, core_op2_o, 4'd0);
        core_quo_i = cr.quo;
        core_rem_i = cr.rem;
        busy = (core_lat != 0) ? core_lat : int'($urandom_range(1, 6));
        core_ready_i = 1'b0;
      end else if (busy > 0) begin
        busy--;
        if (busy == 0) core_ready_i = !core_block;
      end else begin
        core_ready_i = !core_block;
      end
    end
  end

  task automatic push_req(input logic [63:0] a, input logic [63:0] b,
                          input logic [3:0] t);
    int n;
    n = 0;
    @(negedge clk);
    req_vld_i = 1'b1;
    req_op1_i = a;
    req_op2_i = b;
    req_tag_i = t;
    while (!req_rdy_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_rdy_o) begin
      n_cmp++;
      n_err++;
      $display("FAIL push_timeout: tag %0d not accepted", t);
    end
    @(posedge clk);
    #1;
    req_vld_i = 1'b0;
  endtask

  task automatic take_rsp(output rsp_t r, input int lim);
    int n;
    n = 0;
    @(negedge clk);
    while (!rsp_vld_o && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_vld_o) begin
      n_cmp++;
      n_err++;
      $display("FAIL rsp_timeout: no response within %0d cycles", lim);
    end
    r = {rsp_quo_o, rsp_rem_o, rsp_dz_o, rsp_tag_o};
    rsp_rdy_i = 1'b1;
    @(posedge clk);
    #1;
    rsp_rdy_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rsp_t        r;
    rsp_t        e;
    rsp_t        sb[$];
    logic [3:0]  got[$];
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  t;
    logic [63:0] ba[3];
    logic [63:0] bb[3];
    logic [63:0] bq[3];
    int          h0;
    int          n;
    int          idx;
    int          exp_hs;
    bit          drain;

    vt[0]  = '{64'd100, 64'd0, 4'd3, ONES, 64'd100, 1'b1, 0};
    vt[1]  = '{MINV, ONES, 4'd4, MINV, 64'd0, 1'b0, int'(!BYP)};
    vt[2]  = '{64'd100, 64'd7, 4'd5, 64'd14, 64'd2, 1'b0, 1};
    vt[3]  = '{-64'd100, 64'd7, 4'd6, -64'd14, -64'd2, 1'b0, 1};
    vt[4]  = '{64'd100, -64'd7, 4'd7, -64'd14, 64'd2, 1'b0, 1};
    vt[5]  = '{64'd0, 64'd5, 4'd8, 64'd0, 64'd0, 1'b0, int'(!BYP)};
    vt[6]  = '{64'd55, 64'd1, 4'd9, 64'd55, 64'd0, 1'b0, int'(!BYP)};
    vt[7]  = '{64'd7, 64'd100, 4'd10, 64'd0, 64'd7, 1'b0, 1};
    vt[8]  = '{MINV, 64'd0, 4'd11, ONES, MINV, 1'b1, 0};
    vt[9]  = '{64'd0, 64'd0, 4'd12, ONES, 64'd0, 1'b1, 0};
    vt[10] = '{-64'd9, ONES, 4'd13, 64'd9, 64'd0, 1'b0, int'(!BYP)};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rdy", 64'(req_rdy_o), 64'd0);
    chk("rst_rsp_vld", 64'(rsp_vld_o), 64'd0);
    chk("rst_core_vld", 64'(core_vld_o), 64'd0);
    chk("rst_quo", rsp_quo_o, 64'd0);
    chk("rst_tag", 64'(rsp_tag_o), 64'd0);
    chk("rst_op1", core_op1_o, 64'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_rdy", 64'(req_rdy_o), 64'd1);

    // Vector table, one request at a time
    foreach (vt[i]) begin
      h0 = hs_cnt;
      push_req(vt[i].a, vt[i].b, vt[i].t);
      chk("lat_early", 64'(rsp_vld_o), 64'd0);
      @(posedge clk);
      #1;
      if (vt[i].hs == 0) chk("lat_byp", 64'(rsp_vld_o), 64'd1);
      else chk("lat_core", 64'(core_vld_o), 64'd1);
      take_rsp(r, 100);
      chk("vec_quo", r.quo, vt[i].q);
      chk("vec_rem", r.rem, vt[i].r);
      chk("vec_dz", 64'(r.dz), 64'(vt[i].dz));
      chk("vec_tag", 64'(r.tag), 64'(vt[i].t));
      chk("vec_hs", 64'(hs_cnt - h0), 64'(vt[i].hs));
    end

    // Response stall: outputs hold, ready tracks queue space
    push_req(64'd100, 64'd7, 4'd5);
    n = 0;
    while (!rsp_vld_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stall_vld", 64'(rsp_vld_o), 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_hold_vld", 64'(rsp_vld_o), 64'd1);
      chk("stall_hold_quo", rsp_quo_o, 64'd14);
      chk("stall_hold_rem", rsp_rem_o, 64'd2);
      chk("stall_hold_tag", 64'(rsp_tag_o), 64'd5);
      chk("stall_rdy", 64'(req_rdy_o), 64'd1);
    end
    push_req(64'd1, 64'd0, 4'd6);
    @(negedge clk);
    chk("stall_full", 64'(req_rdy_o), 64'd0);
    chk("stall_head", 64'(rsp_tag_o), 64'd5);
    take_rsp(r, 50);
    chk("stall_r1_tag", 64'(r.tag), 64'd5);
    take_rsp(r, 50);
    chk("stall_r2_tag", 64'(r.tag), 64'd6);
    chk("stall_r2_quo", r.quo, ONES);
    chk("stall_r2_rem", r.rem, 64'd1);

    // Back-to-back tags 1,2,3 with a two-entry queue
    ba = '{64'd100, 64'd9, 64'd50};
    bb = '{64'd7, 64'd0, 64'd5};
    bq = '{64'd14, ONES, 64'd10};
    idx = 0;
    for (int c = 0; c < 200 && got.size() < 3; c++) begin
      @(negedge clk);
      if (c == 2) chk("b2b_full", 64'(req_rdy_o), 64'd0);
      rsp_rdy_i = (c >= 2);
      if (idx < 3) begin
        req_vld_i = 1'b1;
        req_op1_i = ba[idx];
        req_op2_i = bb[idx];
        req_tag_i = 4'(idx + 1);
      end else begin
        req_vld_i = 1'b0;
      end
      if (req_vld_i && req_rdy_o) idx++;
      if (rsp_vld_o && rsp_rdy_i) begin
        chk("b2b_tag", 64'(rsp_tag_o), 64'(got.size() + 1));
        chk("b2b_quo", rsp_quo_o, bq[got.size()]);
        got.push_back(rsp_tag_o);
      end
    end
    @(negedge clk);
    req_vld_i = 1'b0;
    rsp_rdy_i = 1'b0;
    chk("b2b_cnt", 64'(got.size()), 64'd3);

    // Core not ready in ISSUE: hold operands, single transfer
    core_block = 1'b1;
    h0 = hs_cnt;
    push_req(64'd100, 64'd7, 4'd9);
    n = 0;
    while (!core_vld_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("iss_vld", 64'(core_vld_o), 64'd1);
      chk("iss_op1", core_op1_o, 64'd100);
      chk("iss_op2", core_op2_o, 64'd7);
      chk("iss_nohs", 64'(hs_cnt - h0), 64'd0);
    end
    core_block = 1'b0;
    take_rsp(r, 100);
    chk("iss_quo", r.quo, 64'd14);
    chk("iss_rem", r.rem, 64'd2);
    chk("iss_dz", 64'(r.dz), 64'd0);
    chk("iss_hs", 64'(hs_cnt - h0), 64'd1);

    // Reset while waiting on the core
    core_lat = 30;
    h0 = hs_cnt;
    push_req(64'd100, 64'd7, 4'd10);
    n = 0;
    while (hs_cnt == h0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rw_hs", 64'(hs_cnt - h0), 64'd1);
    repeat (3) @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("rw_rsp_vld", 64'(rsp_vld_o), 64'd0);
    chk("rw_core_vld", 64'(core_vld_o), 64'd0);
    chk("rw_rdy", 64'(req_rdy_o), 64'd0);
    chk("rw_quo", rsp_quo_o, 64'd0);
    chk("rw_rem", rsp_rem_o, 64'd0);
    chk("rw_op1", core_op1_o, 64'd0);
    chk("rw_op2", core_op2_o, 64'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    core_lat = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rw_no_stale", 64'({rsp_vld_o, core_vld_o}), 64'd0);
    end
    chk("rw_rdy_after", 64'(req_rdy_o), 64'd1);
    push_req(64'd20, 64'd0, 4'd11);
    take_rsp(r, 50);
    chk("rw_new_tag", 64'(r.tag), 64'd11);
    chk("rw_new_rem", r.rem, 64'd20);
    chk("rw_new_dz", 64'(r.dz), 64'd1);

    // Randomized traffic against the reference queue
    h0 = hs_cnt;
    exp_hs = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      drain = (c >= 3500);
      a = gen_op1();
      b = gen_op2();
      t = 4'($urandom);
      req_vld_i = !drain && ($urandom_range(0, 2) != 0);
      req_op1_i = a;
      req_op2_i = b;
      req_tag_i = t;
      rsp_rdy_i = drain || ($urandom_range(0, 3) != 0);
      if (rsp_vld_o && rsp_rdy_i) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rnd_extra: tag %0d with empty model", rsp_tag_o);
        end else begin
          e = sb.pop_front();
          chk("rnd_quo", rsp_quo_o, e.quo);
          chk("rnd_rem", rsp_rem_o, e.rem);
          chk("rnd_dz", 64'(rsp_dz_o), 64'(e.dz));
          chk("rnd_tag", 64'(rsp_tag_o), 64'(e.tag));
        end
      end
      if (req_vld_i && req_rdy_o) begin
        sb.push_back(ref_div(a, b, t));
        if (goes_core(a, b)) exp_hs++;
      end
    end
    @(negedge clk);
    req_vld_i = 1'b0;
    rsp_rdy_i = 1'b0;
    chk("rnd_left", 64'(sb.size()), 64'd0);
    chk("rnd_hs", 64'(hs_cnt - h0), 64'(exp_hs));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
